// File: rtl/add_seq16.sv
// Nibble-serial adder: one 4-bit slice per cycle, result valid NIBBLES cycles after accept, held until out_ready.
// Optional signed-overflow flag on port ovf when ADD_OVF_EN is defined.
module add_seq16 #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
`ifdef ADD_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [3:0]    a_nib, b_nib;
  logic [4:0]    slice;
`ifdef ADD_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    a_nib   = '0;
    b_nib   = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx_q == IW'(k)) begin
        a_nib = a_q[4*k +: 4];
        b_nib = b_q[4*k +: 4];
      end
    end
    slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};

    case (state_q)
      IDLE: begin
`ifdef ADD_OVF_EN
        ovf_d = 1'b0;
`endif
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Untouched nibbles keep their previous contents until overwritten.
        for (int k = 0; k < NIBBLES; k++) begin
          if (idx_q == IW'(k)) sum_d[4*k +: 4] = slice[3:0];
        end
        carry_d = slice[4];
        if (idx_q == IW'(NIBBLES - 1)) begin
          cout_d  = slice[4];
          state_d = DONE;
`ifdef ADD_OVF_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
